gmem_controller: RTL and testbench

- Global-memory controller sitting directly downstream of the per-core data caches.
- Accepts single-word read and write requests from NUM_CONSUMERS cache ports.
- Multiplexes them onto NUM_CHANNELS external memory channels using per-channel round-robin arbitration.
- Relays each memory response back to the originating cache over a valid/ready four-phase handshake.

---
 rtl/gmem_controller.sv | 192 +++++++++++++++++++
 tb/tb_gmem_controller.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gmem_controller.sv
// gmem_controller: routes single-word cache read/write requests onto a set of
// memory channels, each channel arbitrating round-robin across the cache ports
// and relaying the memory response back over a four-phase valid/ready handshake.
module gmem_controller #(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8,
    parameter int NUM_CONSUMERS = 4,
    parameter int NUM_CHANNELS  = 1,
    parameter int WRITE_ENABLE  = 1
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [NUM_CONSUMERS-1:0]                consumer_read_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]                consumer_read_ready,
    output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]                consumer_write_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_write_address,
    input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]                consumer_write_ready,
    output logic [NUM_CHANNELS-1:0]                 mem_read_valid,
    output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_read_address,
    input  logic [NUM_CHANNELS-1:0]                 mem_read_ready,
    input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_read_data,
    output logic [NUM_CHANNELS-1:0]                 mem_write_valid,
    output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_write_address,
    output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_write_data,
    input  logic [NUM_CHANNELS-1:0]                 mem_write_ready
);

    localparam int CW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        READ_WAIT   = 3'd1,
        WRITE_WAIT  = 3'd2,
        READ_RELAY  = 3'd3,
        WRITE_RELAY = 3'd4
    } state_t;

    state_t        state_q  [NUM_CHANNELS];
    state_t        state_d  [NUM_CHANNELS];
    logic [CW-1:0] rr_ptr_q [NUM_CHANNELS];
    logic [CW-1:0] rr_ptr_d [NUM_CHANNELS];
    logic [CW-1:0] owner_q  [NUM_CHANNELS];
    logic [CW-1:0] owner_d  [NUM_CHANNELS];

    logic [NUM_CONSUMERS-1:0]                claim_q, claim_d;
    logic [NUM_CONSUMERS-1:0]                c_rrdy_q, c_rrdy_d;
    logic [NUM_CONSUMERS-1:0]                c_wrdy_q, c_wrdy_d;
    logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] c_rdata_q, c_rdata_d;
    logic [NUM_CHANNELS-1:0]                 m_rv_q, m_rv_d;
    logic [NUM_CHANNELS-1:0]                 m_wv_q, m_wv_d;
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  m_ra_q, m_ra_d;
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  m_wa_q, m_wa_d;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  m_wd_q, m_wd_d;

    logic [NUM_CONSUMERS-1:0] wr_req;
    logic [NUM_CONSUMERS-1:0] taken;
    logic                     found;
    logic [CW-1:0]            pick;
    logic [CW-1:0]            cand;

    // Next-state for every channel; channels are walked in index order so a
    // consumer granted by a lower channel this cycle is invisible to higher ones.
    // Claims released this cycle stay in 'taken' until the following cycle.
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        owner_d   = owner_q;
        claim_d   = claim_q;
        c_rrdy_d  = c_rrdy_q;
        c_wrdy_d  = c_wrdy_q;
        c_rdata_d = c_rdata_q;
        m_rv_d    = m_rv_q;
        m_wv_d    = m_wv_q;
        m_ra_d    = m_ra_q;
        m_wa_d    = m_wa_q;
        m_wd_d    = m_wd_q;
        wr_req    = (WRITE_ENABLE != 0) ? consumer_write_valid : '0;
        taken     = claim_q;
        found     = 1'b0;
        pick      = '0;
        cand      = '0;

        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            case (state_q[ch])
                IDLE: begin
                    found = 1'b0;
                    pick  = '0;
                    for (int k = 0; k < NUM_CONSUMERS; k++) begin
                        cand = CW'((int'(rr_ptr_q[ch]) + k) % NUM_CONSUMERS);
                        if (!found && !taken[cand] &&
                            (consumer_read_valid[cand] || wr_req[cand])) begin
                            found = 1'b1;
                            pick  = cand;
                        end
                    end
                    if (found) begin
                        taken[pick]  = 1'b1;
                        claim_d[pick] = 1'b1;
                        owner_d[ch]  = pick;
                        rr_ptr_d[ch] = CW'((int'(pick) + 1) % NUM_CONSUMERS);
                        if (consumer_read_valid[pick]) begin
                            m_rv_d[ch]  = 1'b1;
                            m_ra_d[ch]  = consumer_read_address[pick];
                            state_d[ch] = READ_WAIT;
                        end else begin
                            m_wv_d[ch]  = 1'b1;
                            m_wa_d[ch]  = consumer_write_address[pick];
                            m_wd_d[ch]  = consumer_write_data[pick];
                            state_d[ch] = WRITE_WAIT;
                        end
                    end
                end
                READ_WAIT: begin
                    if (mem_read_ready[ch]) begin
                        m_rv_d[ch]                = 1'b0;
                        c_rdata_d[owner_q[ch]]    = mem_read_data[ch];
                        c_rrdy_d[owner_q[ch]]     = 1'b1;
                        state_d[ch]               = READ_RELAY;
                    end
                end
                WRITE_WAIT: begin
                    if (mem_write_ready[ch]) begin
                        m_wv_d[ch]            = 1'b0;
                        c_wrdy_d[owner_q[ch]] = 1'b1;
                        state_d[ch]           = WRITE_RELAY;
                    end
                end
                READ_RELAY: begin
                    if (!consumer_read_valid[owner_q[ch]]) begin
                        c_rrdy_d[owner_q[ch]] = 1'b0;
                        claim_d[owner_q[ch]]  = 1'b0;
                        state_d[ch]           = IDLE;
                    end
                end
                WRITE_RELAY: begin
                    if (!consumer_write_valid[owner_q[ch]]) begin
                        c_wrdy_d[owner_q[ch]] = 1'b0;
                        claim_d[owner_q[ch]]  = 1'b0;
                        state_d[ch]           = IDLE;
                    end
                end
                default: state_d[ch] = IDLE;
            endcase
        end
    end

    // Channel FSMs and all registered outputs; reset aborts any transaction silently.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                state_q[ch]  <= IDLE;
                rr_ptr_q[ch] <= '0;
                owner_q[ch]  <= '0;
            end
            claim_q   <= '0;
            c_rrdy_q  <= '0;
            c_wrdy_q  <= '0;
            c_rdata_q <= '0;
            m_rv_q    <= '0;
            m_wv_q    <= '0;
            m_ra_q    <= '0;
            m_wa_q    <= '0;
            m_wd_q    <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            owner_q   <= owner_d;
            claim_q   <= claim_d;
            c_rrdy_q  <= c_rrdy_d;
            c_wrdy_q  <= c_wrdy_d;
            c_rdata_q <= c_rdata_d;
            m_rv_q    <= m_rv_d;
            m_wv_q    <= m_wv_d;
            m_ra_q    <= m_ra_d;
            m_wa_q    <= m_wa_d;
            m_wd_q    <= m_wd_d;
        end
    end

    assign consumer_read_ready  = c_rrdy_q;
    assign consumer_read_data   = c_rdata_q;
    assign mem_read_valid       = m_rv_q;
    assign mem_read_address     = m_ra_q;
    assign consumer_write_ready = (WRITE_ENABLE != 0) ? c_wrdy_q : '0;
    assign mem_write_valid      = (WRITE_ENABLE != 0) ? m_wv_q   : '0;
    assign mem_write_address    = (WRITE_ENABLE != 0) ? m_wa_q   : '0;
    assign mem_write_data       = (WRITE_ENABLE != 0) ? m_wd_q   : '0;

endmodule

// File: tb/tb_gmem_controller.sv
// Bench for gmem_controller: a single-channel instance checked every cycle
// against a transaction-level model, plus a two-channel instance for the
// same-cycle multi-channel arbitration cases.
module tb_gmem_controller;

    logic clk;
    logic reset;

    // single-channel instance
    logic [3:0]      rv, crr, wv, cwr;
    logic [3:0][7:0] ra, crd, wa, wd;
    logic            mrv, mrr, mwv, mwr;
    logic [7:0]      mra, mrd, mwa, mwd;

    // two-channel instance
    logic [3:0]      rv2, crr2, wv2, cwr2;
    logic [3:0][7:0] ra2, crd2, wa2, wd2;
    logic [1:0]      mrv2, mrr2, mwv2, mwr2;
    logic [1:0][7:0] mra2, mrd2, mwa2, mwd2;

    int n_chk;
    int n_fail;
    bit cmp_on;

    gmem_controller u1 (
        .clk(clk), .reset(reset),
        .consumer_read_valid(rv), .consumer_read_address(ra),
        .consumer_read_ready(crr), .consumer_read_data(crd),
        .consumer_write_valid(wv), .consumer_write_address(wa),
        .consumer_write_data(wd), .consumer_write_ready(cwr),
        .mem_read_valid(mrv), .mem_read_address(mra),
        .mem_read_ready(mrr), .mem_read_data(mrd),
        .mem_write_valid(mwv), .mem_write_address(mwa),
        .mem_write_data(mwd), .mem_write_ready(mwr)
    );

    gmem_controller #(.NUM_CHANNELS(2)) u2 (
        .clk(clk), .reset(reset),
        .consumer_read_valid(rv2), .consumer_read_address(ra2),
        .consumer_read_ready(crr2), .consumer_read_data(crd2),
        .consumer_write_valid(wv2), .consumer_write_address(wa2),
        .consumer_write_data(wd2), .consumer_write_ready(cwr2),
        .mem_read_valid(mrv2), .mem_read_address(mra2),
        .mem_read_ready(mrr2), .mem_read_data(mrd2),
        .mem_write_valid(mwv2), .mem_write_address(mwa2),
        .mem_write_data(mwd2), .mem_write_ready(mwr2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Memory answers every outstanding request one cycle after it appears.
    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            mrr = mrv;
            mrd = mra ^ 8'hFF;
            mwr = mwv;
        end
        mrr = 1'b0;
        mwr = 1'b0;
    endtask

    // ---------------- model of the single-channel controller ----------------
    // phase: 0 = free, 1 = request out to memory, 2 = result handed to cache
    int              m_phase, m_owner, m_ptr, m_c;
    bit              m_wr, m_got;
    logic            e_mrv, e_mwv;
    logic [7:0]      e_mra, e_mwa, e_mwd;
    logic [3:0]      e_crr, e_cwr;
    logic [3:0][7:0] e_crd;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_phase = 0; m_owner = 0; m_ptr = 0; m_wr = 0;
            e_mrv = 0; e_mwv = 0; e_mra = 0; e_mwa = 0; e_mwd = 0;
            e_crr = 0; e_cwr = 0; e_crd = 0;
        end else begin
            if (m_phase == 0) begin
                m_got = 0;
                for (int k = 0; k < 4; k++) begin
                    m_c = (m_ptr + k) % 4;
                    if (!m_got && (rv[m_c] || wv[m_c])) begin
                        m_got = 1;
                        m_owner = m_c;
                    end
                end
                if (m_got) begin
                    m_ptr = (m_owner + 1) % 4;
                    m_wr = !rv[m_owner];
                    m_phase = 1;
                    if (!m_wr) begin
                        e_mrv = 1; e_mra = ra[m_owner];
                    end else begin
                        e_mwv = 1; e_mwa = wa[m_owner]; e_mwd = wd[m_owner];
                    end
                end
            end else if (m_phase == 1) begin
                if (!m_wr && mrr) begin
                    e_mrv = 0; e_crr[m_owner] = 1; e_crd[m_owner] = mrd; m_phase = 2;
                end else if (m_wr && mwr) begin
                    e_mwv = 0; e_cwr[m_owner] = 1; m_phase = 2;
                end
            end else begin
                if (!m_wr && !rv[m_owner]) begin
                    e_crr[m_owner] = 0; m_phase = 0;
                end else if (m_wr && !wv[m_owner]) begin
                    e_cwr[m_owner] = 0; m_phase = 0;
                end
            end
        end
    end

    // Every cycle, all single-channel outputs must match the model.
    always @(negedge clk) begin
        if (cmp_on) begin
            chk("cyc mem_read_valid",    32'(mrv), 32'(e_mrv));
            chk("cyc mem_read_address",  32'(mra), 32'(e_mra));
            chk("cyc mem_write_valid",   32'(mwv), 32'(e_mwv));
            chk("cyc mem_write_address", 32'(mwa), 32'(e_mwa));
            chk("cyc mem_write_data",    32'(mwd), 32'(e_mwd));
            chk("cyc cons_read_ready",   32'(crr), 32'(e_crr));
            chk("cyc cons_read_data",    crd,      e_crd);
            chk("cyc cons_write_ready",  32'(cwr), 32'(e_cwr));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int         exp_order [5];
    logic [7:0] gr_addr   [5];
    int         ngr;
    logic       prev_mrv;

    initial begin
        clk = 0; reset = 0; cmp_on = 0; n_chk = 0; n_fail = 0;
        rv = 0; ra = 0; wv = 0; wa = 0; wd = 0; mrr = 0; mrd = 0; mwr = 0;
        rv2 = 0; ra2 = 0; wv2 = 0; wa2 = 0; wd2 = 0; mrr2 = 0; mrd2 = 0; mwr2 = 0;
        exp_order = '{0, 1, 2, 3, 0};
        #1 reset = 1;
        cmp_on = 1;
        tick(); tick();
        chk("reset mem_read_valid", 32'(mrv), 0);
        chk("reset cons_read_ready", 32'(crr), 0);
        chk("reset ch2 mem_read_valid", 32'(mrv2), 0);
        reset = 0;

        // round-robin, all four consumers keep requesting
        for (int c = 0; c < 4; c++) ra[c] = 8'(8'h10 + c);
        rv = 4'hF;
        ngr = 0;
        prev_mrv = 0;
        for (int cyc = 0; cyc < 60 && ngr < 5; cyc++) begin
            tick();
            if (mrv && !prev_mrv) begin
                gr_addr[ngr] = mra;
                ngr++;
            end
            prev_mrv = mrv;
            for (int c = 0; c < 4; c++) rv[c] = !crr[c];
            mrr = mrv;
            mrd = mra ^ 8'hFF;
        end
        chk("rr grant count", 32'(ngr), 5);
        for (int i = 0; i < 5; i++)
            if (i < ngr) chk("rr grant order", 32'(gr_addr[i]), 32'(8'h10 + exp_order[i]));
        rv = 0;
        drain(6);

        // single read: consumer 2, addr 0x3C, memory returns 0xA5 two cycles later
        rv[2] = 1; ra[2] = 8'h3C;
        tick();
        chk("read mem_read_address", 32'(mra), 32'h3C);
        chk("read mem_read_valid", 32'(mrv), 1);
        tick();
        mrr = 1; mrd = 8'hA5;
        tick();
        mrr = 0;
        chk("read ready", 32'(crr[2]), 1);
        chk("read data", 32'(crd[2]), 32'hA5);
        chk("read mem valid drop", 32'(mrv), 0);
        rv[2] = 0;
        tick();
        chk("read ready release", 32'(crr[2]), 0);

        // write path with a 5-cycle memory stall; cache changes its inputs meanwhile
        wv[1] = 1; wa[1] = 8'h10; wd[1] = 8'h77;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("write valid held", 32'(mwv), 1);
            chk("write address held", 32'(mwa), 32'h10);
            chk("write data held", 32'(mwd), 32'h77);
            if (i == 1) begin wa[1] = 8'h55; wd[1] = 8'h11; end
        end
        mwr = 1;
        tick();
        mwr = 0;
        chk("write ready", 32'(cwr[1]), 1);
        chk("write mem valid drop", 32'(mwv), 0);
        wv[1] = 0;
        tick();
        chk("write ready release", 32'(cwr[1]), 0);

        // early valid drop during the memory wait
        rv[0] = 1; ra[0] = 8'h42;
        tick();
        rv[0] = 0;
        tick();
        mrr = 1; mrd = 8'h99;
        tick();
        mrr = 0;
        chk("early drop ready pulse", 32'(crr[0]), 1);
        chk("early drop data", 32'(crd[0]), 32'h99);
        tick();
        chk("early drop ready gone", 32'(crr[0]), 0);
        tick();
        chk("early drop channel idle", 32'(mrv), 0);

        // reset during a write wait
        wv[1] = 1; wa[1] = 8'h20; wd[1] = 8'h33;
        tick();
        chk("rst pre write valid", 32'(mwv), 1);
        #2 reset = 1;
        #1;
        chk("rst async write valid", 32'(mwv), 0);
        chk("rst async write address", 32'(mwa), 0);
        chk("rst async write data", 32'(mwd), 0);
        chk("rst async write ready", 32'(cwr), 0);
        mwr = 1; wv[1] = 0;
        tick();
        reset = 0; mwr = 0;
        rv[0] = 1; ra[0] = 8'h0A;
        rv[2] = 1; ra[2] = 8'h0C;
        tick();
        chk("post-rst grant from consumer 0", 32'(mra), 32'h0A);
        chk("post-rst no write ack", 32'(cwr), 0);
        rv = 0;
        drain(6);

        // two channels: consumer 0 read+write, consumer 3 read
        rv2[0] = 1; wv2[0] = 1; ra2[0] = 8'h01; wa2[0] = 8'h02; wd2[0] = 8'hEE;
        rv2[3] = 1; ra2[3] = 8'h03;
        tick();
        chk("dual ch0 valid", 32'(mrv2[0]), 1);
        chk("dual ch0 addr", 32'(mra2[0]), 32'h01);
        chk("dual ch1 valid", 32'(mrv2[1]), 1);
        chk("dual ch1 addr", 32'(mra2[1]), 32'h03);
        chk("dual no write yet", 32'(mwv2), 0);
        mrr2 = 2'b11; mrd2[0] = 8'hD0; mrd2[1] = 8'h3E;
        tick();
        mrr2 = 0;
        chk("dual c0 data", 32'(crd2[0]), 32'hD0);
        chk("dual c3 data", 32'(crd2[3]), 32'h3E);
        chk("dual read readies", 32'(crr2), 32'b1001);
        chk("dual write held off", 32'(mwv2), 0);
        rv2[0] = 0; rv2[3] = 0;
        tick();
        chk("dual release no regrant", 32'(mwv2), 0);
        tick();
        chk("dual write on ch0 only", 32'(mwv2), 32'b01);
        chk("dual write addr", 32'(mwa2[0]), 32'h02);
        chk("dual write data", 32'(mwd2[0]), 32'hEE);
        mwr2[0] = 1;
        tick();
        mwr2 = 0;
        chk("dual write ready", 32'(cwr2), 32'b0001);
        wv2[0] = 0;
        tick();
        chk("dual write release", 32'(cwr2), 0);

        cmp_on = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
